// File: rtl/timer_pkg.sv
// Shared types and helpers for the MM:SS BCD run/hold timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } stateT;

  typedef logic [3:0] digitT;

  // Same packing as the iLoadBcd / oTimeBcd buses.
  typedef struct packed {
    digitT minT;
    digitT minO;
    digitT secT;
    digitT secO;
  } timeT;

  localparam digitT SEC_TENS_MAX = 4'd5;
  localparam digitT DIGIT_MAX    = 4'd9;

  // Binary value of the two minute digits (0..99).
  function automatic logic [6:0] minutesOf(timeT t);
    return 7'(t.minT) * 7'd10 + 7'(t.minO);
  endfunction

  // True when every digit is a legal BCD digit and the time is within range.
  function automatic logic isValidTime(timeT t, int maxMin);
    return (t.minT <= DIGIT_MAX) && (t.minO <= DIGIT_MAX) &&
           (t.secT <= SEC_TENS_MAX) && (t.secO <= DIGIT_MAX) &&
           (int'(minutesOf(t)) <= maxMin);
  endfunction

endpackage

// File: rtl/sec_edge_sync.sv
// Synchronizer plus rising-edge detector for the asynchronous 1 Hz wave.
// The tick output is combinational from flops and is high for exactly one
// cycle, two cycles after the wave is first sampled high.
module sec_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iAsync,
  output logic oTick
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;

  // Shift the async input through the synchronizer and remember the last value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour.
      syncQ <= {syncQ[SYNC_STAGES-2:0], iAsync};
      prevQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign oTick = syncQ[SYNC_STAGES-1] & ~prevQ;

endmodule

// File: rtl/sec_bcd_timer.sv
// MM:SS run/hold timer in packed BCD, advanced by the 1 Hz wave.
// Build option: define TIMER_COUNTDOWN_EN for a count-down timer that
// expires at 00:00 instead of wrapping after MAX_MIN:59.
module sec_bcd_timer
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iClk1s,
  input  logic        iStart,
  input  logic        iStop,
  input  logic        iClear,
  input  logic        iLoad,
  input  logic [15:0] iLoadBcd,
  output logic [15:0] oTimeBcd,
  output logic        oTick,
  output logic        oRunning,
  output logic        oWrap,
  output logic        oLoadErr
);

  stateT state, nextState;
  timeT  timeQ, timeNext, loadVal, stepVal;
  logic  tickRaw, countEn, loadOk, loadErr, startOk, stepWrap;

  sec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uEdge (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iAsync (iClk1s),
    .oTick  (tickRaw)
  );

  assign loadVal  = timeT'(iLoadBcd);
  assign oTimeBcd = timeQ;

  // One-second step of the time value, with the wrap/expiry flag.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    stepVal  = timeQ;
    stepWrap = 1'b0;
`ifdef TIMER_COUNTDOWN_EN
    if (timeQ == '0) begin
      stepWrap = 1'b1;
    end else begin
      if (timeQ.secO != 4'd0) begin
        stepVal.secO = timeQ.secO - 4'd1;
      end else begin
        stepVal.secO = DIGIT_MAX;
        if (timeQ.secT != 4'd0) begin
          stepVal.secT = timeQ.secT - 4'd1;
        end else begin
          stepVal.secT = SEC_TENS_MAX;
          if (timeQ.minO != 4'd0) begin
            stepVal.minO = timeQ.minO - 4'd1;
          end else begin
            stepVal.minO = DIGIT_MAX;
            stepVal.minT = timeQ.minT - 4'd1;
          end
        end
      end
      stepWrap = (stepVal == '0);
    end
`else
    if (timeQ.secO != DIGIT_MAX) begin
      stepVal.secO = timeQ.secO + 4'd1;
    end else begin
      stepVal.secO = 4'd0;
      if (timeQ.secT != SEC_TENS_MAX) begin
        stepVal.secT = timeQ.secT + 4'd1;
      end else begin
        stepVal.secT = 4'd0;
        if (int'(minutesOf(timeQ)) >= MAX_MIN) begin
          stepVal.minT = 4'd0;
          stepVal.minO = 4'd0;
          stepWrap     = 1'b1;
        end else if (timeQ.minO != DIGIT_MAX) begin
          stepVal.minO = timeQ.minO + 4'd1;
        end else begin
          stepVal.minO = 4'd0;
          stepVal.minT = timeQ.minT + 4'd1;
        end
      end
    end
`endif
  end

  // Command qualification: count, load accept/reject, start.
  always_comb begin
    countEn = tickRaw && (state == RUN) && !iClear && !iStop && !iLoad;
    loadOk  = iLoad && !iClear && (state != RUN) && isValidTime(loadVal, MAX_MIN);
    loadErr = iLoad && !iClear && !loadOk;
    startOk = iStart && !iStop && !iClear && (state != RUN);
`ifdef TIMER_COUNTDOWN_EN
    if ((loadOk ? loadVal : timeQ) == '0) startOk = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic; clear beats stop beats start.
  always_comb begin
    nextState = state;
    if (iClear) begin
      nextState = IDLE;
    end else if (iStop && (state == RUN)) begin
      nextState = HOLD;
    end else if (startOk) begin
      nextState = RUN;
    end else if (loadOk) begin
      nextState = HOLD;
`ifdef TIMER_COUNTDOWN_EN
    end else if (countEn && stepWrap) begin
      nextState = IDLE;
`endif
    end
  end

  // Output/datapath next values.
  always_comb begin
    timeNext = timeQ;
    if (iClear)       timeNext = '0;
    else if (loadOk)  timeNext = loadVal;
    else if (countEn) timeNext = stepVal;
  end

  // Registered outputs and time value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      timeQ    <= '0;
      oTick    <= 1'b0;
      oRunning <= 1'b0;
      oWrap    <= 1'b0;
      oLoadErr <= 1'b0;
    end else begin
      timeQ    <= timeNext;
      oTick    <= tickRaw;
      oRunning <= (nextState == RUN);
      oWrap    <= countEn && stepWrap;
      oLoadErr <= loadErr;
    end
  end

endmodule
